// File: rtl/periph_reg_arbiter_pkg.sv
// Shared types and constants for the peripheral register-bus arbiter.
package periph_reg_arbiter_pkg;

  localparam int unsigned RegAddrW = 32;
  localparam int unsigned RegDataW = 32;
  localparam int unsigned RegStrbW = RegDataW / 8;

  localparam int unsigned PeriphRegArbNumReq  = 2;
  localparam int unsigned PeriphRegArbTimeout = 255;

  // Requester slot assignment
  localparam int unsigned REG_ARB_BRIDGE_IDX = 0;
  localparam int unsigned REG_ARB_DBG_IDX    = 1;

  localparam logic [RegAddrW-1:0] UART_REG_START_ADDR = 32'h1A10_2000;

  typedef struct packed {
    logic [RegAddrW-1:0] addr;
    logic                write;
    logic [RegDataW-1:0] wdata;
    logic [RegStrbW-1:0] wstrb;
    logic                valid;
  } reg_req_t;

  typedef struct packed {
    logic [RegDataW-1:0] rdata;
    logic                error;
    logic                ready;
  } reg_rsp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/periph_reg_arbiter_if.sv
// Bundles requester-side and peripheral-side register-bus signals.
interface periph_reg_arbiter_if
  import periph_reg_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = PeriphRegArbNumReq
) ();

  reg_req_t [NumReq-1:0] req_i;
  reg_rsp_t [NumReq-1:0] rsp_o;
  reg_req_t              req_o;
  reg_rsp_t              rsp_i;

  // Arbiter view
  modport slave (
    input  req_i,
    input  rsp_i,
    output rsp_o,
    output req_o
  );

  // Environment view: requesters plus peripheral demux
  modport master (
    output req_i,
    output rsp_i,
    input  rsp_o,
    input  req_o
  );

endinterface

// File: rtl/periph_reg_arbiter_rr_prio_sel.sv
// Combinational round-robin finder: first valid index at or above ptr, wrapping.
module rr_prio_sel
  import periph_reg_arbiter_pkg::*;
#(
  parameter  int unsigned NumReq = PeriphRegArbNumReq,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   idx,
  output logic              any_valid
);

  logic [IdxW-1:0] cand;

  // Scan offsets 0..NumReq-1 from ptr; the first hit wins
  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(ptr) + off) % NumReq);
      if (!any_valid && valid[cand]) begin
        any_valid = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter sharing one peripheral register-bus port among NumReq requesters.
// Optional busy watchdog compiled in with PERIPH_REG_ARB_TIMEOUT_EN.
module periph_reg_arbiter
  import periph_reg_arbiter_pkg::*;
#(
  parameter  int unsigned NumReq        = PeriphRegArbNumReq,
  parameter  int unsigned TimeoutCycles = PeriphRegArbTimeout,
  localparam int unsigned IdxW          = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  periph_reg_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic [IdxW-1:0]      grant_idx_o,
  output logic                 timeout_o
);

  if (NumReq < 2 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("periph_reg_arbiter: NumReq must be >= 2 and TimeoutCycles >= 1");
  end

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       next_ptr;
  logic [IdxW-1:0]       sel_idx;
  logic                  sel_any;
  logic [NumReq-1:0]     valid_vec;
  logic                  gnt_valid;
  logic                  complete;
  logic                  withdraw;
  logic                  timeout_hit;
  reg_req_t              req_c;
  reg_rsp_t [NumReq-1:0] rsp_c;

  // Gather requester valids for the round-robin search
  always_comb begin
    valid_vec = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      valid_vec[i] = bus.req_i[i].valid;
    end
  end

  rr_prio_sel #(
    .NumReq (NumReq)
  ) u_rr_prio_sel (
    .valid     (valid_vec),
    .ptr       (rr_ptr_q),
    .idx       (sel_idx),
    .any_valid (sel_any)
  );

  assign gnt_valid = bus.req_i[grant_q].valid;
  assign complete  = (state_q == ST_BUSY) && gnt_valid && bus.rsp_i.ready;
  assign withdraw  = (state_q == ST_BUSY) && !gnt_valid;
  assign next_ptr  = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + IdxW'(1);

`ifdef PERIPH_REG_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The current BUSY cycle is cycle cnt_q+1, so the limit is hit at cnt_q == TimeoutCycles-1
  assign timeout_hit = (state_q == ST_BUSY) && gnt_valid && !bus.rsp_i.ready &&
                       (cnt_q == CntW'(TimeoutCycles - 1));

  // Busy-cycle counter: zero on BUSY entry, counts non-completing BUSY cycles
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_BUSY) && !complete && !withdraw && !timeout_hit) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and bus muxing; rdata/error pass straight through from the peripheral
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    req_c    = '0;
    rsp_c    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_d = sel_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        req_c                = bus.req_i[grant_q];
        rsp_c[grant_q]       = bus.rsp_i;
        // A withdrawn requester never sees ready
        rsp_c[grant_q].ready = bus.rsp_i.ready & gnt_valid;
        if (withdraw) begin
          state_d = ST_IDLE;
        end else if (complete) begin
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          req_c.valid          = 1'b0;
          rsp_c[grant_q]       = '0;
          rsp_c[grant_q].ready = 1'b1;
          rsp_c[grant_q].error = 1'b1;
          rr_ptr_d             = next_ptr;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.req_o   = req_c;
  assign bus.rsp_o   = rsp_c;
  assign busy_o      = (state_q == ST_BUSY);
  assign grant_idx_o = grant_q;
  assign timeout_o   = timeout_hit;

endmodule

// File: tb/tb_periph_reg_arbiter.sv
// Directed self-checking bench for periph_reg_arbiter (NumReq=2, TimeoutCycles=4).
// Covers PERIPH_REG_ARB_TIMEOUT_EN both defined and undefined.
module tb_periph_reg_arbiter;
  import periph_reg_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [0:0] grant_idx;
  logic timeout;
  int n_chk = 0;
  int n_fail = 0;

  periph_reg_arbiter_if #(.NumReq(2)) bus ();

  periph_reg_arbiter #(
    .NumReq        (2),
    .TimeoutCycles (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .busy_o      (busy),
    .grant_idx_o (grant_idx),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  reg_req_t rq_rd0;
  reg_req_t rq_wr1;
  reg_req_t rq_idle;
  reg_rsp_t rs_none;

  initial begin
    rq_rd0  = '{addr: UART_REG_START_ADDR, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
    rq_wr1  = '{addr: 32'h1A10_4008, write: 1'b1, wdata: 32'hCAFE_0123, wstrb: 4'hF, valid: 1'b1};
    rq_idle = '0;
    rs_none = '0;

    rst = 1'b1;
    bus.req_i = '0;
    bus.rsp_i = '0;
    tick();
    tick();

    // Reset values
    rst = 1'b0;
    settle();
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_grant", 80'(grant_idx), 80'(0));
    chk("rst_timeout", 80'(timeout), 80'(0));
    chk("rst_req_o", 80'(bus.req_o), 80'(0));
    chk("rst_rsp_o", 80'(bus.rsp_o), 80'(0));
    chk("rst_rr_ptr", 80'(dut.rr_ptr_q), 80'(0));

    // Single read from requester 0, zero-wait peripheral
    tick();
    bus.req_i[REG_ARB_BRIDGE_IDX] = rq_rd0;
    settle();
    chk("rd_idle_valid", 80'(bus.req_o.valid), 80'(0));
    chk("rd_idle_ready0", 80'(bus.rsp_o[0].ready), 80'(0));
    tick();
    bus.rsp_i = '{rdata: 32'h5A, error: 1'b0, ready: 1'b1};
    settle();
    chk("rd_busy", 80'(busy), 80'(1));
    chk("rd_grant", 80'(grant_idx), 80'(0));
    chk("rd_req_o", 80'(bus.req_o), 80'(rq_rd0));
    chk("rd_rdata", 80'(bus.rsp_o[0].rdata), 80'(32'h5A));
    chk("rd_ready", 80'(bus.rsp_o[0].ready), 80'(1));
    chk("rd_other_rsp", 80'(bus.rsp_o[1]), 80'(0));
    tick();
    bus.req_i[0] = rq_idle;
    bus.rsp_i = rs_none;
    settle();
    chk("rd_done_busy", 80'(busy), 80'(0));
    chk("rd_ptr", 80'(dut.rr_ptr_q), 80'(1));

    // Reset back to pointer 0, then contention with a zero-wait peripheral
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_i[0] = rq_rd0;
    bus.req_i[1] = rq_wr1;
    bus.rsp_i = '{rdata: 32'h11, error: 1'b0, ready: 1'b1};
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("ct_idle_busy", 80'(busy), 80'(0));
      chk("ct_idle_ready", 80'({bus.rsp_o[1].ready, bus.rsp_o[0].ready}), 80'(0));
      tick();
      chk("ct_grant", 80'(grant_idx), 80'(k % 2));
      chk("ct_win_ready", 80'(bus.rsp_o[k % 2].ready), 80'(1));
      chk("ct_lose_ready", 80'(bus.rsp_o[(k + 1) % 2].ready), 80'(0));
      tick();
    end
    bus.req_i = '0;
    bus.rsp_i = rs_none;
    settle();
    chk("ct_ptr", 80'(dut.rr_ptr_q), 80'(0));

    // Wait states: requester 1 granted, 5 stalled BUSY cycles, requester 0 waiting
    bus.req_i[1] = rq_wr1;
    tick();
    bus.req_i[0] = rq_rd0;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("ws_busy", 80'(busy), 80'(1));
      chk("ws_grant", 80'(grant_idx), 80'(1));
      chk("ws_req_o", 80'(bus.req_o), 80'(rq_wr1));
      chk("ws_ready1", 80'(bus.rsp_o[1].ready), 80'(0));
      chk("ws_ready0", 80'(bus.rsp_o[0].ready), 80'(0));
      tick();
    end
    bus.rsp_i = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    settle();
    chk("ws_done_ready1", 80'(bus.rsp_o[1].ready), 80'(1));
    chk("ws_done_ready0", 80'(bus.rsp_o[0].ready), 80'(0));
    tick();
    bus.req_i[1] = rq_idle;
    bus.rsp_i = rs_none;
    settle();
    chk("ws_idle_busy", 80'(busy), 80'(0));
    tick();
    bus.rsp_i = '{rdata: 32'h77, error: 1'b0, ready: 1'b1};
    settle();
    chk("wrap_grant", 80'(grant_idx), 80'(0));
    chk("wrap_ready0", 80'(bus.rsp_o[0].ready), 80'(1));
    chk("wrap_rdata0", 80'(bus.rsp_o[0].rdata), 80'(32'h77));
    tick();
    bus.req_i[0] = rq_idle;
    bus.rsp_i = rs_none;
    settle();
    chk("wrap_ptr", 80'(dut.rr_ptr_q), 80'(1));

    // Reset pulsed in the 2nd BUSY cycle
    bus.req_i[0] = rq_rd0;
    tick();
    settle();
    chk("mr_busy1", 80'(busy), 80'(1));
    tick();
    rst = 1'b1;
    settle();
    chk("mr_busy2", 80'(busy), 80'(1));
    tick();
    rst = 1'b0;
    bus.req_i[0] = rq_idle;
    bus.req_i[1] = rq_wr1;
    settle();
    chk("mr_busy_after", 80'(busy), 80'(0));
    chk("mr_valid_after", 80'(bus.req_o.valid), 80'(0));
    chk("mr_ptr_after", 80'(dut.rr_ptr_q), 80'(0));
    chk("mr_ready0_after", 80'(bus.rsp_o[0].ready), 80'(0));
    tick();
    bus.rsp_i = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    settle();
    chk("mr_grant1", 80'(grant_idx), 80'(1));
    chk("mr_ready1", 80'(bus.rsp_o[1].ready), 80'(1));
    tick();
    bus.req_i[1] = rq_idle;
    bus.rsp_i = rs_none;
    settle();
    chk("mr_ptr_end", 80'(dut.rr_ptr_q), 80'(0));

    // Withdrawal: granted requester 1 drops valid while peripheral signals ready
    bus.req_i[1] = rq_wr1;
    tick();
    settle();
    chk("wd_grant", 80'(grant_idx), 80'(1));
    chk("wd_valid", 80'(bus.req_o.valid), 80'(1));
    tick();
    bus.req_i[1] = rq_idle;
    bus.rsp_i = '{rdata: 32'h99, error: 1'b0, ready: 1'b1};
    settle();
    chk("wd_no_ready", 80'(bus.rsp_o[1].ready), 80'(0));
    chk("wd_req_valid", 80'(bus.req_o.valid), 80'(0));
    tick();
    bus.rsp_i = rs_none;
    bus.req_i[0] = rq_rd0;
    bus.req_i[1] = rq_wr1;
    settle();
    chk("wd_idle", 80'(busy), 80'(0));
    chk("wd_ptr", 80'(dut.rr_ptr_q), 80'(0));
    tick();
    bus.rsp_i = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    settle();
    chk("wd_next_grant", 80'(grant_idx), 80'(0));
    tick();
    bus.req_i = '0;
    bus.rsp_i = rs_none;
    settle();
    chk("wd_end_ptr", 80'(dut.rr_ptr_q), 80'(1));

    // Peripheral never ready on requester 1
    bus.req_i[1] = rq_wr1;
    bus.rsp_i = '{rdata: 32'hAA, error: 1'b0, ready: 1'b0};
    tick();
`ifdef PERIPH_REG_ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("to_pre_timeout", 80'(timeout), 80'(0));
      chk("to_pre_ready", 80'(bus.rsp_o[1].ready), 80'(0));
      tick();
    end
    settle();
    chk("to_timeout", 80'(timeout), 80'(1));
    chk("to_rsp", 80'(bus.rsp_o[1]), 80'({32'h0, 1'b1, 1'b1}));
    chk("to_req_valid", 80'(bus.req_o.valid), 80'(0));
    tick();
    bus.req_i[1] = rq_idle;
    settle();
    chk("to_idle", 80'(busy), 80'(0));
    chk("to_pulse_end", 80'(timeout), 80'(0));
    chk("to_ptr", 80'(dut.rr_ptr_q), 80'(0));

    // Peripheral answers exactly on the limit cycle: completion wins
    bus.req_i[0] = rq_rd0;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
    end
    bus.rsp_i = '{rdata: 32'h33, error: 1'b0, ready: 1'b1};
    settle();
    chk("lim_timeout", 80'(timeout), 80'(0));
    chk("lim_rsp", 80'(bus.rsp_o[0]), 80'({32'h33, 1'b0, 1'b1}));
    tick();
    bus.req_i[0] = rq_idle;
    bus.rsp_i = rs_none;
    settle();
    chk("lim_idle", 80'(busy), 80'(0));
`else
    for (int c = 0; c < 1000; c++) begin
      settle();
      chk("nto_busy", 80'(busy), 80'(1));
      chk("nto_timeout", 80'(timeout), 80'(0));
      tick();
    end
    bus.req_i[1] = rq_idle;
    tick();
    settle();
    chk("nto_idle", 80'(busy), 80'(0));
    chk("nto_ptr", 80'(dut.rr_ptr_q), 80'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_reg_arbiter.md
# periph_reg_arbiter

Round-robin arbiter sharing the single peripheral register-bus port (SoC control, boot ROM, fast interrupt control, UART decode region) among several register-bus requesters, such as the AXI-to-reg bridge and a debug or DMA register master. It grants one requester at a time and holds the grant until the peripheral completes the transaction. It sits between the requesters and the reg demux that applies `RegMap`. An optional watchdog terminates transactions the peripheral never acknowledges.

## Interface
- `NumReq`, default 2: number of requesters; must be ≥2.
- `TimeoutCycles`, default 255: busy-cycle limit before a forced error; must be ≥1. Used only when the timeout feature is compiled in.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: reset. Synchronous, active-high.
- `req_i` in, `reg_req_t[NumReq]`: requester requests (`addr`, `write`, `wdata`, `wstrb`, `valid`).
- `rsp_o` out, `reg_rsp_t[NumReq]`: responses to the requesters (`rdata`, `error`, `ready`).
- `req_o` out, `reg_req_t`: request to the peripheral demux.
- `rsp_i` in, `reg_rsp_t`: response from the peripheral demux.
- `busy_o` out, 1: a grant is held (state BUSY).
- `grant_idx_o` out, `$clog2(NumReq)`: index of the current or last granted requester.
- `timeout_o` out, 1: one-cycle pulse when a transaction is force-terminated.

## Operation
- The reg-bus handshake completes in a cycle where `valid` and `ready` are both high. Requesters hold the request stable until that cycle.
- FSM states are IDLE and BUSY.
- IDLE:
  - `req_o.valid`=0.
  - All `rsp_o[i].ready`=0.
  - If any `req_i[i].valid` is high, select the first valid index searching from `rr_ptr` upward, modulo `NumReq`.
  - Register the selection into `grant_q`, then go to BUSY.
- BUSY:
  - `req_o` = `req_i[grant_q]`.
  - `rsp_o[grant_q]` = `rsp_i`.
  - Every other `rsp_o` has `ready`=0, `error`=0, `rdata`=0.
- Completion, when `rsp_i.ready` && `req_i[grant_q].valid`: set `rr_ptr` ← (`grant_q`+1) mod `NumReq`, then go to IDLE.
- Withdrawal, when the granted requester drops `valid`: this is a protocol violation. Go to IDLE with `rr_ptr` unchanged and produce no response.
- `rdata` and `error` from the peripheral pass through combinationally.
- Arbitration ignores `write`; reads and writes are treated identically.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `grant_q`=0.
  - `busy_o`=0, `grant_idx_o`=0, `timeout_o`=0.
  - `req_o` all zero, all `rsp_o` zero.
- Latency:
  - `valid` rising in cycle 0 (IDLE) gives `req_o.valid` in cycle 1.
  - A zero-wait peripheral completes in cycle 1.
  - The minimum transaction is 2 cycles.
  - An IDLE cycle always separates grants, so peak throughput is 1 transaction per 2 cycles.
- Simultaneous requests: the pointer order decides the winner. After a completion, the winner's index becomes lowest priority.
- A requester asserting `valid` during another requester's BUSY waits. Its `ready` stays 0.
- Wrap-around: `rr_ptr` after index `NumReq`-1 is 0.
- Reset asserted mid-BUSY: the next cycle is IDLE with reset values. The in-flight transaction is abandoned with no response to the requester.

## Configuration
- Macro: `PERIPH_REG_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without completion.
  - When the count reaches `TimeoutCycles` without completion, in that cycle:
    - `req_o.valid`=0.
    - `rsp_o[grant_q]` drives `ready`=1, `error`=1, `rdata`=0, ignoring `rsp_i`.
    - `timeout_o`=1.
    - `rr_ptr` advances as for a completion; next state is IDLE.
  - If the peripheral acknowledges in the same cycle the limit is reached, the completion wins and no timeout is raised.
  - Counter width is `$clog2(TimeoutCycles+1)`.
- Undefined:
  - No counter is instantiated.
  - `timeout_o` is tied 0.
  - BUSY waits indefinitely.

## Structure
- `core_v_mcu_pkg` gains:
  - `PeriphRegArbNumReq`.
  - `PeriphRegArbTimeout`, default 255.
  - Requester index constants `REG_ARB_BRIDGE_IDX`=0 and `REG_ARB_DBG_IDX`=1.
- `reg_req_t` and `reg_rsp_t` come from the existing package typedefs.
- One sub-module: `rr_prio_sel`, a combinational round-robin first-valid finder with inputs valid vector and pointer and output index plus any-valid.
- FSM, counter, and muxing stay in the top module.

## Test plan
- Single read: `req_i[0]` reads `addr`=`UART_REG_START_ADDR`, peripheral `ready` in cycle 1 with `rdata`=0x5A.
  - Expect `rsp_o[0]`: `rdata`=0x5A, `ready`=1 in cycle 1.
  - Then `busy_o`=0.
- Contention: both requesters valid in cycle 0, zero-wait peripheral.
  - Grant order 0, 1, 0, 1 over four transactions.
  - `grant_idx_o` matches; the loser sees `ready`=0 while waiting.
- Wait states: peripheral holds `ready` low for 5 BUSY cycles.
  - `req_o` stays stable with `grant_idx_o`=1.
  - Completion on the 6th BUSY cycle.
  - `rsp_o[0].ready` stays 0 throughout.
- Reset mid-BUSY: `rst_i` pulsed in the 2nd BUSY cycle.
  - Next cycle: `busy_o`=0, `req_o.valid`=0, `rr_ptr`=0.
  - A subsequent request to index 1 is granted normally.
- Timeout with `PERIPH_REG_ARB_TIMEOUT_EN` defined and `TimeoutCycles`=4: peripheral never ready.
  - The 4th BUSY cycle gives `rsp_o[grant].error`=1, `ready`=1, `timeout_o`=1.
  - The next cycle is IDLE.
  - Without the macro, the same stimulus keeps BUSY for 1000 cycles.
- Withdrawal: granted requester drops `valid` in BUSY.
  - Next cycle IDLE, `rr_ptr` unchanged, no `ready` issued.
